// File: rtl/mat_data_mem_arbiter_pkg.sv
// ============================================================================
// Module      : mat_data_mem_arbiter_pkg
// Description : Shared mat types for the MatDataMem arbiter: write-op encoding
//               and arbiter state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mat_data_mem_arbiter_pkg;

  // One shortreal lane, carried as its IEEE-754 bit pattern.
  localparam int c_LANE_BITS = 32;

  typedef enum logic [1:0] {
    DATA_MEM_NO_WRITE    = 2'd0,
    DATA_MEM_WRITE_VEC   = 2'd1,
    DATA_MEM_WRITE_LANE0 = 2'd2
  } MatDataMemWriteOp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } MatArbState_t;

  function automatic MatArbState_t own_state(input logic port);
    return port ? OWN1 : OWN0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mat_arb_pick.sv
// ============================================================================
// Module      : mat_arb_pick
// Description : Chooses the next owner when leaving IDLE. Round-robin on
//               simultaneous requests when MAT_ARB_ROUND_ROBIN_EN is defined,
//               fixed port-0 priority otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mat_arb_pick (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_owner,
  output logic o_pick_valid,
  output logic o_pick_port
);

  assign o_pick_valid = i_valid0 | i_valid1;

`ifdef MAT_ARB_ROUND_ROBIN_EN
  assign o_pick_port = (i_valid0 && i_valid1) ? ~i_last_owner : i_valid1;
`else
  logic w_unused_last_owner;
  assign w_unused_last_owner = i_last_owner;
  assign o_pick_port = ~i_valid0 & i_valid1;
`endif

endmodule

`default_nettype wire

// File: rtl/mat_data_mem_arbiter.sv
// ============================================================================
// Module      : mat_data_mem_arbiter
// Description : Shares one MatDataMem between MatControl (port 0) and a host/DMA
//               loader (port 1) with registered grants and a burst limit.
//               Optional macro: MAT_ARB_ROUND_ROBIN_EN (see mat_arb_pick).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mat_data_mem_arbiter
  import mat_data_mem_arbiter_pkg::*;
#(
  parameter int WIDTH              = 16,
  parameter int DATA_MEM_ADDR_SIZE = 32,
  parameter int MAX_BURST          = 8,
  parameter int BURST_CNT_SIZE     = $clog2(MAX_BURST + 1)
) (
  input  logic                                   clock,
  input  logic                                   reset,

  input  logic                                   req0_valid,
  input  logic                                   req0_lock,
  input  logic [DATA_MEM_ADDR_SIZE-1:0]          req0_read_addr,
  input  MatDataMemWriteOp_t                     req0_write_op,
  input  logic [DATA_MEM_ADDR_SIZE-1:0]          req0_write_addr,
  input  logic [WIDTH-1:0][c_LANE_BITS-1:0]      req0_data_in,
  output logic                                   req0_grant,
  output logic [WIDTH-1:0][c_LANE_BITS-1:0]      req0_data_out,

  input  logic                                   req1_valid,
  input  logic                                   req1_lock,
  input  logic [DATA_MEM_ADDR_SIZE-1:0]          req1_read_addr,
  input  MatDataMemWriteOp_t                     req1_write_op,
  input  logic [DATA_MEM_ADDR_SIZE-1:0]          req1_write_addr,
  input  logic [WIDTH-1:0][c_LANE_BITS-1:0]      req1_data_in,
  output logic                                   req1_grant,
  output logic [WIDTH-1:0][c_LANE_BITS-1:0]      req1_data_out,

  output logic [DATA_MEM_ADDR_SIZE-1:0]          data_mem_read_addr,
  input  logic [WIDTH-1:0][c_LANE_BITS-1:0]      data_mem_data_out,
  output MatDataMemWriteOp_t                     data_mem_write_op,
  output logic [DATA_MEM_ADDR_SIZE-1:0]          data_mem_write_addr,
  output logic [WIDTH-1:0][c_LANE_BITS-1:0]      data_mem_data_in,
  output logic                                   busy
);

  MatArbState_t              r_state;
  MatArbState_t              w_next_state;
  logic [BURST_CNT_SIZE-1:0] r_burst_cnt;
  logic                      r_last_owner;
  logic                      w_pick_valid;
  logic                      w_pick_port;
  logic                      w_burst_done;

  mat_arb_pick u_pick (
    .i_valid0     (req0_valid),
    .i_valid1     (req1_valid),
    .i_last_owner (r_last_owner),
    .o_pick_valid (w_pick_valid),
    .o_pick_port  (w_pick_port)
  );

  // r_burst_cnt holds the beats completed before the current one, so the
  // current beat is the MAX_BURST-th once the count reaches MAX_BURST-1.
  assign w_burst_done = (r_burst_cnt >= BURST_CNT_SIZE'(MAX_BURST - 1));

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) w_next_state = own_state(w_pick_port);
      end
      OWN0: begin
        if (req0_valid) begin
          if (!req0_lock && req1_valid && w_burst_done) w_next_state = OWN1;
        end else begin
          w_next_state = req1_valid ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (req1_valid) begin
          if (!req1_lock && req0_valid && w_burst_done) w_next_state = OWN0;
        end else begin
          w_next_state = req0_valid ? OWN0 : IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_burst_cnt  <= '0;
      r_last_owner <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state)
        r_burst_cnt <= '0;
      else if (r_state != IDLE && r_burst_cnt != BURST_CNT_SIZE'(MAX_BURST))
        r_burst_cnt <= r_burst_cnt + 1'b1;
      if (w_next_state != r_state && w_next_state != IDLE)
        r_last_owner <= (w_next_state == OWN1);
    end
  end

  assign req0_grant    = (r_state == OWN0);
  assign req1_grant    = (r_state == OWN1);
  assign busy          = req0_grant | req1_grant;
  assign req0_data_out = data_mem_data_out;
  assign req1_data_out = data_mem_data_out;

  // A granted owner that has dropped valid must not write; nor may anything
  // write in a reset cycle.
  always_comb begin
    data_mem_read_addr  = '0;
    data_mem_write_addr = '0;
    data_mem_data_in    = '0;
    data_mem_write_op   = DATA_MEM_NO_WRITE;
    unique case (r_state)
      OWN0: begin
        data_mem_read_addr  = req0_read_addr;
        data_mem_write_addr = req0_write_addr;
        data_mem_data_in    = req0_data_in;
        if (req0_valid) data_mem_write_op = req0_write_op;
      end
      OWN1: begin
        data_mem_read_addr  = req1_read_addr;
        data_mem_write_addr = req1_write_addr;
        data_mem_data_in    = req1_data_in;
        if (req1_valid) data_mem_write_op = req1_write_op;
      end
      default: ;
    endcase
    if (reset) data_mem_write_op = DATA_MEM_NO_WRITE;
  end

endmodule

`default_nettype wire

// File: tb/tb_mat_data_mem_arbiter.sv
// ============================================================================
// Module      : tb_mat_data_mem_arbiter
// Description : Self-checking bench for mat_data_mem_arbiter with a small
//               MatDataMem model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mat_data_mem_arbiter;
  import mat_data_mem_arbiter_pkg::*;

  localparam int WIDTH = 16;
  localparam int AW    = 32;
  localparam logic [31:0] ONE   = 32'h3F80_0000;
  localparam logic [31:0] TWO   = 32'h4000_0000;
  localparam logic [31:0] THREE = 32'h4040_0000;

  logic clock;
  logic reset;
  logic req0_valid, req0_lock, req1_valid, req1_lock;
  logic [AW-1:0] req0_read_addr, req0_write_addr, req1_read_addr, req1_write_addr;
  MatDataMemWriteOp_t req0_write_op, req1_write_op, data_mem_write_op;
  logic [WIDTH-1:0][31:0] req0_data_in, req1_data_in, req0_data_out, req1_data_out;
  logic [WIDTH-1:0][31:0] data_mem_data_out, data_mem_data_in;
  logic [AW-1:0] data_mem_read_addr, data_mem_write_addr;
  logic req0_grant, req1_grant, busy;

  int checks   = 0;
  int failures = 0;

  mat_data_mem_arbiter dut (
    .clock               (clock),
    .reset               (reset),
    .req0_valid          (req0_valid),
    .req0_lock           (req0_lock),
    .req0_read_addr      (req0_read_addr),
    .req0_write_op       (req0_write_op),
    .req0_write_addr     (req0_write_addr),
    .req0_data_in        (req0_data_in),
    .req0_grant          (req0_grant),
    .req0_data_out       (req0_data_out),
    .req1_valid          (req1_valid),
    .req1_lock           (req1_lock),
    .req1_read_addr      (req1_read_addr),
    .req1_write_op       (req1_write_op),
    .req1_write_addr     (req1_write_addr),
    .req1_data_in        (req1_data_in),
    .req1_grant          (req1_grant),
    .req1_data_out       (req1_data_out),
    .data_mem_read_addr  (data_mem_read_addr),
    .data_mem_data_out   (data_mem_data_out),
    .data_mem_write_op   (data_mem_write_op),
    .data_mem_write_addr (data_mem_write_addr),
    .data_mem_data_in    (data_mem_data_in),
    .busy                (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // MatDataMem model: combinational read, write at the clock edge.
  logic [WIDTH-1:0][31:0] mem [0:31];
  logic mem_init;
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else begin
      case (data_mem_write_op)
        DATA_MEM_WRITE_VEC:   mem[data_mem_write_addr[4:0]]    <= data_mem_data_in;
        DATA_MEM_WRITE_LANE0: mem[data_mem_write_addr[4:0]][0] <= data_mem_data_in[0];
        default: ;
      endcase
    end
  end
  assign data_mem_data_out = mem[data_mem_read_addr[4:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic v0, l0, v1, l1, g0, g1;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic v0, l0, v1, l1, g0, g1);
    vec_t r;
    r.v0 = v0; r.l0 = l0; r.v1 = v1; r.l1 = l1; r.g0 = g0; r.g1 = g1;
    vecs.push_back(r);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_init = 1'b1;
    req0_valid = 0; req0_lock = 0; req1_valid = 0; req1_lock = 0;
    req0_read_addr = '0; req0_write_addr = '0; req1_read_addr = '0; req1_write_addr = '0;
    req0_write_op = DATA_MEM_NO_WRITE; req1_write_op = DATA_MEM_NO_WRITE;
    req0_data_in = '0; req1_data_in = '0;
    step(); step();
    mem_init = 1'b0;

    // Reset state
    check("rst_g0", 64'(req0_grant), 64'd0);
    check("rst_g1", 64'(req1_grant), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wop", 64'(data_mem_write_op), 64'(DATA_MEM_NO_WRITE));
    check("rst_raddr", 64'(data_mem_read_addr), 64'd0);
    check("rst_waddr", 64'(data_mem_write_addr), 64'd0);
    reset = 1'b0;

    // Write 1.0 to address 5 from port 0
    req0_valid = 1; req0_write_op = DATA_MEM_WRITE_VEC; req0_write_addr = 5;
    req0_data_in = {WIDTH{ONE}};
    step();
    check("wr_grant_latency", 64'(req0_grant), 64'd1);
    check("wr_not_yet", 64'(mem[5][0]), 64'd0);
    step();
    check("wr_mem5_lane0", 64'(mem[5][0]), 64'(ONE));
    check("wr_mem5_lane15", 64'(mem[5][15]), 64'(ONE));
    check("wr_g1_low", 64'(req1_grant), 64'd0);
    req0_write_op = DATA_MEM_NO_WRITE; req0_read_addr = 5;
    #1;
    check("rd_data_out", 64'(req0_data_out[3]), 64'(ONE));

    // Owner drops valid while still presenting a write
    req0_valid = 0; req0_write_op = DATA_MEM_WRITE_VEC; req0_write_addr = 7;
    req0_data_in = {WIDTH{TWO}};
    #1;
    check("drop_grant_still", 64'(req0_grant), 64'd1);
    check("drop_wop_nowrite", 64'(data_mem_write_op), 64'(DATA_MEM_NO_WRITE));
    step();
    check("drop_grant_falls", 64'(req0_grant), 64'd0);
    check("drop_mem7", 64'(mem[7][0]), 64'd0);
    req0_write_op = DATA_MEM_NO_WRITE;

    // Grant sequencing table: inputs for one cycle, grants after its edge
    add(1,0,0,0, 1,0); add(1,0,0,0, 1,0); add(0,0,0,0, 0,0); add(0,0,1,0, 0,1);
    for (int i = 0; i < 7; i++) add(1,0,1,0, 0,1);
    add(1,0,1,0, 1,0);
    for (int i = 0; i < 7; i++) add(1,0,1,0, 1,0);
    add(1,0,1,0, 0,1);
    for (int i = 0; i < 20; i++) add(1,0,1,1, 0,1);
    add(1,0,1,0, 1,0);
    for (int i = 0; i < 20; i++) add(1,1,1,0, 1,0);
    add(1,0,1,0, 0,1);
    add(1,0,0,0, 1,0);
    add(0,0,0,0, 0,0);
`ifdef MAT_ARB_ROUND_ROBIN_EN
    add(1,0,1,0, 0,1);
`else
    add(1,0,1,0, 1,0);
`endif
    add(0,0,0,0, 0,0);
    // Both valid straight after reset-like IDLE from a port-1 history
    add(0,0,1,0, 0,1); add(0,0,0,0, 0,0);
`ifdef MAT_ARB_ROUND_ROBIN_EN
    add(1,0,1,0, 1,0);
`else
    add(1,0,1,0, 1,0);
`endif
    add(0,0,0,0, 0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      req0_valid = vecs[i].v0; req0_lock = vecs[i].l0;
      req1_valid = vecs[i].v1; req1_lock = vecs[i].l1;
      step();
      if (req0_grant !== vecs[i].g0 || req1_grant !== vecs[i].g1 ||
          busy !== (vecs[i].g0 | vecs[i].g1)) begin
        failures++;
        $display("FAIL vec[%0d] g0/g1/busy actual=%b%b%b required=%b%b%b", i,
                 req0_grant, req1_grant, busy, vecs[i].g0, vecs[i].g1, vecs[i].g0 | vecs[i].g1);
      end
      checks++;
    end
    req0_valid = 0; req0_lock = 0; req1_valid = 0; req1_lock = 0;

    // Reset during a port 1 burst
    req1_valid = 1; req1_write_op = DATA_MEM_WRITE_VEC; req1_write_addr = 9;
    req1_data_in = {WIDTH{TWO}};
    step();
    check("rb_g1", 64'(req1_grant), 64'd1);
    step();
    check("rb_mem9_written", 64'(mem[9][0]), 64'(TWO));
    req1_data_in = {WIDTH{THREE}};
    reset = 1'b1;
    #1;
    check("rb_wop_in_reset", 64'(data_mem_write_op), 64'(DATA_MEM_NO_WRITE));
    step();
    check("rb_g0", 64'(req0_grant), 64'd0);
    check("rb_g1_dropped", 64'(req1_grant), 64'd0);
    check("rb_busy", 64'(busy), 64'd0);
    check("rb_mem9_kept", 64'(mem[9][0]), 64'(TWO));
    reset = 1'b0; req1_valid = 0; req1_write_op = DATA_MEM_NO_WRITE;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
